uart_bus_cmd: RTL
=================

Name: uart_bus_cmd

Overview:
- Host-to-bus command path: receives 8N1 UART bytes on `din`, parses 2- or 3-byte read/write commands, and runs one bus cycle per command as bus master (adr_o/dat_o/we_o/stb_o, ack_i/dat_i).
- Each finished cycle produces a one-cycle response record (ack flag, address, data).
- That record feeds the existing bus-monitor FIFO/UART transmit path, so the host sees a {ack, adr, dat} triple per command.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); minimum 4.
- TIMEOUT, 255, bus cycles to wait for ack_i before abort (used only with BUS_TIMEOUT_EN).

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- din  in  1  UART serial input, idle high
- adr_o  out  8  bus address
- dat_o  out  8  bus write data
- we_o  out  1  1 = write cycle, 0 = read cycle
- stb_o  out  1  bus strobe, held until ack_i or abort
- ack_i  in  1  bus acknowledge
- dat_i  in  8  bus read data, valid when ack_i=1
- resp_valid  out  1  one-cycle pulse: response record valid
- resp_ack  out  1  1 = cycle acked, 0 = aborted
- resp_adr  out  8  address of completed cycle
- resp_dat  out  8  read data (read), write data echo (write), 0x00 on abort
- busy  out  1  parser not in P_OP, or a bus cycle pending
- err_o  out  1  one-cycle pulse on framing error, bad opcode or overrun

Behaviour:
- Reset (async, rst_ni=0): all outputs 0.
  - din synchronizer flops set to 1; RX and parser return to idle/P_OP; counters cleared.
  - Reset during a bus cycle drops stb_o immediately; no response is emitted.
- RX path:
  - 2-flop synchronizer on din.
  - Falling edge in RX idle starts a frame. Start bit is re-sampled at CLKS_PER_BIT/2; if high, it is a glitch: return to idle, no error.
  - 8 data bits are sampled LSB first, each CLKS_PER_BIT after the previous sample.
  - Stop bit sampled: 1 gives byte strobe rx_stb; 0 gives framing error (err_o pulse, byte discarded, parser forced to P_OP).
- Command format:
  - Byte0 = opcode: 0x00 read, 0x01 write.
  - Byte1 = address.
  - Byte2 = data (write only).
- Parser FSM:
  - P_OP: on rx_stb, opcode 0x00/0x01 latches we and goes to P_ADR. Any other opcode pulses err_o and stays in P_OP.
  - P_ADR: on rx_stb, latch adr_o. Write goes to P_DAT; read goes to P_BUS.
  - P_DAT: on rx_stb, latch dat_o, go to P_BUS.
  - P_BUS: stb_o=1 starting the cycle after entry.
    - When ack_i=1 is sampled with stb_o=1: stb_o=0 next cycle; latch dat_i (read) or dat_o (write); go to P_RESP.
    - ack_i while stb_o=0 is ignored.
  - P_RESP: resp_valid=1 for exactly one cycle, resp_ack=1, then P_OP. resp_* fields hold their value until the next response.
- Latency: final stop-bit sample to stb_o=1 is 2 cycles; ack_i sample to resp_valid is 1 cycle.
- Overrun: rx_stb while in P_BUS or P_RESP drops the byte, pulses err_o, and does not disturb the bus cycle. The RX path keeps receiving.
- dat_o holds its last value on read cycles; we_o is stable for the whole cycle.
- Back-to-back commands with no idle gap between UART frames must all execute.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to P_BUS and increments each cycle stb_o=1.
  - If it reaches TIMEOUT without ack_i: stb_o=0 next cycle; response emitted with resp_ack=0, resp_dat=0x00, resp_adr=adr_o.
  - ack_i in the same cycle the counter reaches TIMEOUT wins: normal acked response.
- Undefined: no counter; P_BUS waits for ack_i indefinitely.

Test Plan:
- Write: send 0x01,0x2A,0x5C with ack_i on the 3rd stb_o cycle -> we_o=1, adr_o=0x2A, dat_o=0x5C, stb_o high 3 cycles; resp_valid one pulse with resp_ack=1, resp_adr=0x2A, resp_dat=0x5C.
- Read: send 0x00,0x10; bus returns dat_i=0xA7 with ack_i after 1 cycle -> we_o=0, adr_o=0x10; response {1, 0x10, 0xA7}; busy=0 after the response.
- Errors:
  - Opcode 0x7F -> err_o pulse, no stb_o.
  - Next, byte with stop bit=0 -> err_o pulse, parser in P_OP.
  - Then a valid read 0x00,0x03 -> completes normally.
- Overrun: hold ack_i low while sending a 4th byte 0x55 after a write command -> err_o pulse; after ack the response is unchanged; 0x55 is not taken as an opcode.
- BUS_TIMEOUT_EN, TIMEOUT=8, ack_i never asserted on read 0x00,0x44 -> stb_o high exactly 8 cycles, response {0, 0x44, 0x00}. Without the macro, stb_o stays high after 1000 cycles.
- Reset: assert rst_ni=0 mid-stb_o, asynchronous to clk -> stb_o, resp_valid, err_o, busy are 0 before the next clock edge; after release, a write 0x01,0x00,0xFF executes correctly.

Source files
------------

// File: rtl/uart_bus_cmd.sv
// UART (8N1) command receiver that runs one bus-master read/write cycle per command
// and emits a {ack, adr, dat} response record. Define BUS_TIMEOUT_EN to abort unacked cycles.
//
// rx state | meaning
// R_IDLE   | line idle, waiting for a falling edge
// R_START  | half-bit wait, start bit re-checked
// R_DATA   | sampling 8 data bits, LSB first
// R_STOP   | sampling stop bit
//
// p state  | meaning
// P_OP     | waiting for opcode byte
// P_ADR    | waiting for address byte
// P_DAT    | waiting for write-data byte
// P_BUS    | bus cycle in progress (stb_o from the cycle after entry)
// P_RESP   | response record valid for one cycle
module uart_bus_cmd #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT      = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       din,
    output logic [7:0] adr_o,
    output logic [7:0] dat_o,
    output logic       we_o,
    output logic       stb_o,
    input  logic       ack_i,
    input  logic [7:0] dat_i,
    output logic       resp_valid,
    output logic       resp_ack,
    output logic [7:0] resp_adr,
    output logic [7:0] resp_dat,
    output logic       busy,
    output logic       err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF - 1);

    if (CLKS_PER_BIT < 4) begin : g_cpb_check
        $error("uart_bus_cmd: CLKS_PER_BIT must be at least 4");
    end
    if (TIMEOUT < 1) begin : g_timeout_check
        $error("uart_bus_cmd: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
    typedef enum logic [2:0] {P_OP, P_ADR, P_DAT, P_BUS, P_RESP} p_state_e;

    logic             din_s1_q, din_s1_d;
    logic             din_s2_q, din_s2_d;
    logic             din_prev_q, din_prev_d;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             rx_stb_q, rx_stb_d;
    logic             rx_ferr_q, rx_ferr_d;
    logic [7:0]       rx_byte_q, rx_byte_d;

    p_state_e         p_state_q, p_state_d;
    logic             we_q, we_d;
    logic [7:0]       adr_q, adr_d;
    logic [7:0]       dat_q, dat_d;
    logic             stb_q, stb_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_ack_q, resp_ack_d;
    logic [7:0]       resp_adr_q, resp_adr_d;
    logic [7:0]       resp_dat_q, resp_dat_d;
    logic             err_q, err_d;

`ifdef BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
`endif

    always_comb begin
        din_s1_d   = din;
        din_s2_d   = din_s1_q;
        din_prev_d = din_s2_q;
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        rx_stb_d   = 1'b0;
        rx_ferr_d  = 1'b0;
        rx_byte_d  = rx_byte_q;
        case (rx_state_q)
            R_IDLE: begin
                if (din_prev_q && !din_s2_q) begin
                    rx_state_d = R_START;
                    cnt_d      = HALF_RELOAD;
                end
            end
            R_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (din_s2_q) begin
                    rx_state_d = R_IDLE;
                end else begin
                    rx_state_d = R_DATA;
                    cnt_d      = BIT_RELOAD;
                    bit_idx_d  = 3'd0;
                end
            end
            R_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shreg_d   = {din_s2_q, shreg_q[7:1]};
                    cnt_d     = BIT_RELOAD;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) rx_state_d = R_STOP;
                end
            end
            R_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rx_state_d = R_IDLE;
                    if (din_s2_q) begin
                        rx_stb_d  = 1'b1;
                        rx_byte_d = shreg_q;
                    end else begin
                        rx_ferr_d = 1'b1;
                    end
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        p_state_d    = p_state_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        stb_d        = stb_q;
        resp_valid_d = 1'b0;
        resp_ack_d   = resp_ack_q;
        resp_adr_d   = resp_adr_q;
        resp_dat_d   = resp_dat_q;
        err_d        = 1'b0;
`ifdef BUS_TIMEOUT_EN
        to_cnt_d     = '0;
`endif
        case (p_state_q)
            P_OP: begin
                if (rx_stb_q) begin
                    if (rx_byte_q == 8'h00 || rx_byte_q == 8'h01) begin
                        we_d      = rx_byte_q[0];
                        p_state_d = P_ADR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            P_ADR: begin
                if (rx_stb_q) begin
                    adr_d     = rx_byte_q;
                    p_state_d = we_q ? P_DAT : P_BUS;
                end
            end
            P_DAT: begin
                if (rx_stb_q) begin
                    dat_d     = rx_byte_q;
                    p_state_d = P_BUS;
                end
            end
            P_BUS: begin
                // bytes arriving mid-cycle are overruns; the cycle itself is untouched
                if (rx_stb_q) err_d = 1'b1;
                stb_d = 1'b1;
`ifdef BUS_TIMEOUT_EN
                to_cnt_d = stb_q ? to_cnt_q + 1'b1 : to_cnt_q;
`endif
                if (stb_q && ack_i) begin
                    stb_d        = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_ack_d   = 1'b1;
                    resp_adr_d   = adr_q;
                    resp_dat_d   = we_q ? dat_q : dat_i;
                    p_state_d    = P_RESP;
                end
`ifdef BUS_TIMEOUT_EN
                else if (stb_q && to_cnt_q == TO_LAST) begin
                    stb_d        = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_ack_d   = 1'b0;
                    resp_adr_d   = adr_q;
                    resp_dat_d   = 8'h00;
                    p_state_d    = P_RESP;
                end
`endif
            end
            P_RESP: begin
                if (rx_stb_q) err_d = 1'b1;
                p_state_d = P_OP;
            end
            default: p_state_d = P_OP;
        endcase
        // a framing error aborts a half-parsed command, never a running bus cycle
        if (rx_ferr_q) begin
            err_d = 1'b1;
            if (p_state_q == P_ADR || p_state_q == P_DAT) p_state_d = P_OP;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            din_s1_q     <= 1'b1;
            din_s2_q     <= 1'b1;
            din_prev_q   <= 1'b1;
            rx_state_q   <= R_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shreg_q      <= 8'h00;
            rx_stb_q     <= 1'b0;
            rx_ferr_q    <= 1'b0;
            rx_byte_q    <= 8'h00;
            p_state_q    <= P_OP;
            we_q         <= 1'b0;
            adr_q        <= 8'h00;
            dat_q        <= 8'h00;
            stb_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_ack_q   <= 1'b0;
            resp_adr_q   <= 8'h00;
            resp_dat_q   <= 8'h00;
            err_q        <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            din_s1_q     <= din_s1_d;
            din_s2_q     <= din_s2_d;
            din_prev_q   <= din_prev_d;
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            rx_stb_q     <= rx_stb_d;
            rx_ferr_q    <= rx_ferr_d;
            rx_byte_q    <= rx_byte_d;
            p_state_q    <= p_state_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            stb_q        <= stb_d;
            resp_valid_q <= resp_valid_d;
            resp_ack_q   <= resp_ack_d;
            resp_adr_q   <= resp_adr_d;
            resp_dat_q   <= resp_dat_d;
            err_q        <= err_d;
`ifdef BUS_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    assign adr_o      = adr_q;
    assign dat_o      = dat_q;
    assign we_o       = we_q;
    assign stb_o      = stb_q;
    assign resp_valid = resp_valid_q;
    assign resp_ack   = resp_ack_q;
    assign resp_adr   = resp_adr_q;
    assign resp_dat   = resp_dat_q;
    assign busy       = (p_state_q != P_OP);
    assign err_o      = err_q;

endmodule
